// File: rtl/mips_pkg.sv
// mips_pkg: shared control-group layout, ALU op encodings and opcodes for the MIPS pipeline
package mips_pkg;
    localparam int WB_W  = 2;
    localparam int M_W   = 3;
    localparam int EXE_W = 4;

    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    localparam int M_BRANCH    = 2;
    localparam int M_MEM_READ  = 1;
    localparam int M_MEM_WRITE = 0;

    localparam int EXE_REG_DST   = 3;
    localparam int EXE_ALU_OP_HI = 2;
    localparam int EXE_ALU_OP_LO = 1;
    localparam int EXE_ALU_SRC   = 0;

    typedef enum logic [1:0] {
        ALU_MEM   = 2'b00,
        ALU_BEQ   = 2'b01,
        ALU_RTYPE = 2'b10
    } alu_op_e;

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [5:0] OP_BEQ = 6'd4;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, EX-side registered outputs and stall status of the ID/EX stage
interface id_ex_stage_if
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [WB_W-1:0]   id_wb;
    logic [M_W-1:0]    id_m;
    logic [EXE_W-1:0]  id_exe;
    logic [DATA_W-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              flush;
    logic              ex_valid;
    logic [WB_W-1:0]   ex_wb;
    logic [M_W-1:0]    ex_m;
    logic [EXE_W-1:0]  ex_exe;
    logic [DATA_W-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic              stall;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_valid, id_wb, id_m, id_exe, id_pc_plus4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, flush,
        input  ex_valid, ex_wb, ex_m, ex_exe, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, stall, stall_cycles
    );

    modport slave (
        input  id_valid, id_wb, id_m, id_exe, id_pc_plus4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, flush,
        output ex_valid, ex_wb, ex_m, ex_exe, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, stall, stall_cycles
    );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register a load in EX has not yet produced
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_mem_read,
    output logic              load_use
);
    // a load's rt is its destination, so it only counts as a source for non-loads
    assign load_use = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                      ((ex_rt == id_rs) | ((ex_rt == id_rt) & ~id_mem_read));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, MEM flush and stall-cycle counting
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    logic              load_use, bubble, valid_q;
    logic [WB_W-1:0]   wb_q;
    logic [M_W-1:0]    m_q;
    logic [EXE_W-1:0]  exe_q;
    logic [DATA_W-1:0] pc_q, rs_data_q, rt_data_q, imm_q;
    logic [REG_AW-1:0] rs_q, rt_q, rd_q;
    logic [CNT_W-1:0]  cnt_q;

    load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
        .ex_valid    (valid_q),
        .ex_mem_read (m_q[M_MEM_READ]),
        .ex_rt       (rt_q),
        .id_valid    (bus.id_valid),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_mem_read (bus.id_m[M_MEM_READ]),
        .load_use    (load_use)
    );

    // a flush squashes the hazard, so the stall and its count are suppressed
    assign bus.stall = load_use & ~bus.flush;
    assign bubble    = bus.flush | bus.stall | ~bus.id_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            wb_q      <= '0;
            m_q       <= '0;
            exe_q     <= '0;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= ~bubble;
            wb_q      <= bubble ? '0 : bus.id_wb;
            m_q       <= bubble ? '0 : bus.id_m;
            exe_q     <= bubble ? '0 : bus.id_exe;
            pc_q      <= bus.id_pc_plus4;
            rs_data_q <= bus.id_rs_data;
            rt_data_q <= bus.id_rt_data;
            imm_q     <= bus.id_imm;
            rs_q      <= bus.id_rs;
            rt_q      <= bus.id_rt;
            rd_q      <= bus.id_rd;
            if (bus.stall && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.ex_valid     = valid_q;
    assign bus.ex_wb        = wb_q;
    assign bus.ex_m         = m_q;
    assign bus.ex_exe       = exe_q;
    assign bus.ex_pc_plus4  = pc_q;
    assign bus.ex_rs_data   = rs_data_q;
    assign bus.ex_rt_data   = rt_data_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_rs        = rs_q;
    assign bus.ex_rt        = rt_q;
    assign bus.ex_rd        = rd_q;
    assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random stimulus against a behavioural ID/EX model, plus a narrow-counter twin for saturation
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int KIND_R = 0, KIND_LW = 1, KIND_SW = 2, KIND_BEQ = 3;
    localparam int SMALL_MAX = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, flush;
    logic [1:0] id_wb;
    logic [2:0] id_m;
    logic [3:0] id_exe;
    logic [31:0] id_pc, id_rs_d, id_rt_d, id_imm;
    logic [4:0] id_rs, id_rt, id_rd;

    int n_total = 0, n_pass = 0;

    logic e_valid, e_known;
    logic [1:0] e_wb;
    logic [2:0] e_m;
    logic [3:0] e_exe;
    logic [31:0] e_pc, e_rsd, e_rtd, e_imm;
    logic [4:0] e_rs, e_rt, e_rd;
    int cnt, cnt_s;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) m_if ();
    id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  s_if ();

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(m_if.slave));
    id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  dut_small (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));

    assign m_if.id_valid = id_valid;     assign s_if.id_valid = id_valid;
    assign m_if.id_wb = id_wb;           assign s_if.id_wb = id_wb;
    assign m_if.id_m = id_m;             assign s_if.id_m = id_m;
    assign m_if.id_exe = id_exe;         assign s_if.id_exe = id_exe;
    assign m_if.id_pc_plus4 = id_pc;     assign s_if.id_pc_plus4 = id_pc;
    assign m_if.id_rs_data = id_rs_d;    assign s_if.id_rs_data = id_rs_d;
    assign m_if.id_rt_data = id_rt_d;    assign s_if.id_rt_data = id_rt_d;
    assign m_if.id_imm = id_imm;         assign s_if.id_imm = id_imm;
    assign m_if.id_rs = id_rs;           assign s_if.id_rs = id_rs;
    assign m_if.id_rt = id_rt;           assign s_if.id_rt = id_rt;
    assign m_if.id_rd = id_rd;           assign s_if.id_rd = id_rd;
    assign m_if.flush = flush;           assign s_if.flush = flush;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // the ID instruction's sources are rs, plus rt unless it is a load
    function automatic logic model_stall();
        logic reads_rt;
        logic hazard;
        reads_rt = (id_m[1] == 1'b0);
        hazard = e_valid && e_m[1] && e_rt != 0 && id_valid &&
                 (e_rt == id_rs || (reads_rt && e_rt == id_rt));
        return hazard && !flush;
    endfunction

    task automatic model_reset();
        {e_valid, e_wb, e_m, e_exe, e_pc, e_rsd, e_rtd, e_imm, e_rs, e_rt, e_rd} = '0;
        e_known = 1'b1;
        cnt = 0;
        cnt_s = 0;
    endtask

    task automatic model_update(input logic st);
        if (!rst_n) model_reset();
        else begin
            if (st) begin
                cnt = (cnt < 65535) ? cnt + 1 : cnt;
                cnt_s = (cnt_s < SMALL_MAX) ? cnt_s + 1 : cnt_s;
            end
            if (flush || st || !id_valid) begin
                e_valid = 1'b0;
                {e_wb, e_m, e_exe} = '0;
                e_known = 1'b0;
                e_rt = id_rt;
            end else begin
                e_valid = 1'b1;
                e_known = 1'b1;
                {e_wb, e_m, e_exe} = {id_wb, id_m, id_exe};
                {e_pc, e_rsd, e_rtd, e_imm} = {id_pc, id_rs_d, id_rt_d, id_imm};
                {e_rs, e_rt, e_rd} = {id_rs, id_rt, id_rd};
            end
        end
    endtask

    task automatic check_outputs();
        check("ex_valid", m_if.ex_valid, e_valid);
        check("ex_wb", m_if.ex_wb, e_wb);
        check("ex_m", m_if.ex_m, e_m);
        check("ex_exe", m_if.ex_exe, e_exe);
        check("stall_cycles", m_if.stall_cycles, cnt);
        check("stall_cycles_small", s_if.stall_cycles, cnt_s);
        if (e_known) begin
            check("ex_pc_plus4", m_if.ex_pc_plus4, e_pc);
            check("ex_rs_data", m_if.ex_rs_data, e_rsd);
            check("ex_rt_data", m_if.ex_rt_data, e_rtd);
            check("ex_imm", m_if.ex_imm, e_imm);
            check("ex_rs", m_if.ex_rs, e_rs);
            check("ex_rt", m_if.ex_rt, e_rt);
            check("ex_rd", m_if.ex_rd, e_rd);
        end
    endtask

    task automatic cycle();
        logic st;
        #2;
        st = model_stall();
        check("stall", m_if.stall, st);
        @(posedge clk);
        model_update(st);
        #1 check_outputs();
    endtask

    task automatic set_instr(input int kind, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid = 1'b1;
        case (kind)
            KIND_R:  begin id_wb = 2'b10; id_m = 3'b000; id_exe = {1'b1, ALU_RTYPE, 1'b0}; end
            KIND_LW: begin id_wb = 2'b11; id_m = 3'b010; id_exe = {1'b0, ALU_MEM, 1'b1}; end
            KIND_SW: begin id_wb = 2'b00; id_m = 3'b001; id_exe = {1'b0, ALU_MEM, 1'b1}; end
            default: begin id_wb = 2'b00; id_m = 3'b100; id_exe = {1'b0, ALU_BEQ, 1'b0}; end
        endcase
        id_pc = $urandom; id_rs_d = $urandom; id_rt_d = $urandom; id_imm = $urandom;
        id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic rand_inputs();
        id_valid = 1'($urandom); id_wb = 2'($urandom); id_m = 3'($urandom); id_exe = 4'($urandom);
        id_pc = $urandom; id_rs_d = $urandom; id_rt_d = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        flush = 1'($urandom);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        rand_inputs();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            cycle();
        end
        check("rst_ex_valid", m_if.ex_valid, 0);
        check("rst_ex_pc", m_if.ex_pc_plus4, 0);
        check("rst_ex_rd", m_if.ex_rd, 0);

        rst_n = 1'b1;
        flush = 1'b0;
        set_instr(KIND_R, 5'd1, 5'd2, 5'd3);
        cycle();
        check("rel_ex_valid", m_if.ex_valid, 1);
        check("rel_ex_wb", m_if.ex_wb, 2);
        check("rel_ex_exe", m_if.ex_exe, 12);

        set_instr(KIND_LW, 5'd1, 5'd8, 5'd0);
        cycle();
        set_instr(KIND_R, 5'd8, 5'd2, 5'd4);
        #1 check("lu_stall", m_if.stall, 1);
        cycle();
        check("lu_bubble_valid", m_if.ex_valid, 0);
        check("lu_bubble_m", m_if.ex_m, 0);
        #1 check("lu_stall_drop", m_if.stall, 0);
        cycle();
        check("lu_add_in_ex", m_if.ex_valid, 1);
        check("lu_count", m_if.stall_cycles, 1);

        set_instr(KIND_LW, 5'd1, 5'd0, 5'd0);
        cycle();
        set_instr(KIND_R, 5'd0, 5'd2, 5'd4);
        #1 check("r0_no_stall", m_if.stall, 0);
        cycle();

        set_instr(KIND_LW, 5'd1, 5'd9, 5'd0);
        cycle();
        set_instr(KIND_LW, 5'd3, 5'd9, 5'd0);
        #1 check("lw_rt_no_stall", m_if.stall, 0);
        cycle();
        set_instr(KIND_SW, 5'd1, 5'd9, 5'd0);
        #1 check("sw_rt_stall", m_if.stall, 1);
        cycle();
        cycle();

        set_instr(KIND_LW, 5'd1, 5'd8, 5'd0);
        cycle();
        set_instr(KIND_R, 5'd8, 5'd2, 5'd4);
        flush = 1'b1;
        #1 check("flush_no_stall", m_if.stall, 0);
        cycle();
        check("flush_bubble", m_if.ex_valid, 0);
        check("flush_count", m_if.stall_cycles, 2);
        flush = 1'b0;

        set_instr(KIND_R, 5'd1, 5'd2, 5'd3);
        cycle();
        for (int i = 0; i < 10; i++) begin
            logic [31:0] pc;
            logic [1:0] wb;
            set_instr(($urandom_range(0, 1) == 0) ? KIND_R : KIND_BEQ,
                      5'($urandom_range(10, 20)), 5'($urandom_range(10, 20)), 5'($urandom_range(10, 20)));
            pc = id_pc;
            wb = id_wb;
            #1 check("tp_no_stall", m_if.stall, 0);
            cycle();
            check("tp_pc", m_if.ex_pc_plus4, pc);
            check("tp_wb", m_if.ex_wb, wb);
        end

        set_instr(KIND_LW, 5'd1, 5'd8, 5'd0);
        cycle();
        set_instr(KIND_R, 5'd8, 5'd2, 5'd4);
        rst_n = 1'b0;
        #1 check("mid_rst_stall_before", m_if.stall, 1);
        cycle();
        check("mid_rst_valid", m_if.ex_valid, 0);
        check("mid_rst_stall_after", m_if.stall, 0);
        check("mid_rst_count", m_if.stall_cycles, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            set_instr($urandom_range(0, 3), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            id_valid = ($urandom_range(0, 99) < 85);
            flush = ($urandom_range(0, 99) < 10);
            rst_n = ($urandom_range(0, 999) >= 5);
            cycle();
        end
        rst_n = 1'b1;
        flush = 1'b0;

        for (int i = 0; i < 20; i++) begin
            set_instr(KIND_LW, 5'd1, 5'd5, 5'd0);
            cycle();
            set_instr(KIND_R, 5'd5, 5'd6, 5'd7);
            cycle();
            cycle();
        end
        check("sat_small", s_if.stall_cycles, SMALL_MAX);
        set_instr(KIND_LW, 5'd1, 5'd5, 5'd0);
        cycle();
        set_instr(KIND_R, 5'd5, 5'd6, 5'd7);
        cycle();
        check("sat_small_hold", s_if.stall_cycles, SMALL_MAX);
        check("sat_main", m_if.stall_cycles, cnt);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage, directly downstream of the opcode control decoder.
- Registers the decoder's wb/m/exe control groups together with ID operands, register addresses, immediate and PC+4 into the EX stage.
- Detects load-use hazards and stalls the front end while injecting a single-cycle bubble.
- Applies branch flush from MEM and keeps a saturating stall-cycle counter.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields.
- REG_AW, 5, register address width.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- id_valid  input  1  ID holds a real instruction.
- id_wb  input  2  wb[1]=reg_write, wb[0]=mem_to_reg.
- id_m  input  3  m[2]=branch, m[1]=mem_read, m[0]=mem_write.
- id_exe  input  4  exe[3]=reg_dst, exe[2:1]=alu_op (10 R-type, 01 beq, 00 lw/sw), exe[0]=alu_src.
- id_pc_plus4  input  DATA_W  PC+4 of the ID instruction.
- id_rs_data, id_rt_data  input  DATA_W  register file read data.
- id_imm  input  DATA_W  sign-extended immediate.
- id_rs, id_rt, id_rd  input  REG_AW  register addresses.
- flush  input  1  branch taken, resolved in MEM.
- ex_valid  output  1  EX holds a real instruction.
- ex_wb  output  2  registered control group, same bit map as the input.
- ex_m  output  3  registered control group, same bit map as the input.
- ex_exe  output  4  registered control group, same bit map as the input.
- ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm  output  DATA_W  registered data fields.
- ex_rs, ex_rt, ex_rd  output  REG_AW  registered register addresses.
- stall  output  1  combinational; hold PC and IF/ID this cycle.
- stall_cycles  output  CNT_W  count of cycles with stall=1.

Behaviour:
- Reset (rst_n=0 at a clock edge): every registered output is 0, including ex_valid, all control groups, all data and address fields, and stall_cycles.
- Reset overrides flush and stall.
- Latency: exactly one cycle from ID inputs to ex_* outputs.
- load_use = ex_valid & ex_m[1] & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt & ~id_m[1])).
  - rt is not treated as a source when ID is a load.
  - Register 0 never causes a hazard.
- stall = load_use & ~flush; combinational from current inputs and state.
- Per-edge priority when not in reset:
  1. flush=1: ex_valid, ex_wb, ex_m and ex_exe load 0. Data and address fields load from the inputs; their values are don't-care.
  2. stall=1 (bubble): same as flush. The upstream holds IF/ID, so the same instruction is re-presented next cycle.
  3. id_valid=0: same as bubble.
  4. Otherwise: all ex_* fields load from the inputs and ex_valid loads 1.
- Single-cycle stall guaranteed: after a bubble ex_m[1]=0, so stall deasserts on the next cycle.
- Back-to-back loads hitting the next instruction produce one bubble each.
- flush and load_use in the same cycle: stall=0 and a bubble is inserted. The counter does not increment.
- stall_cycles increments by 1 at each edge where stall=1. It saturates at all-ones and never wraps; it clears only on reset.
- Reset asserted mid-stall: the next cycle shows ex_valid=0 and stall=0.

Decomposition:
- Shared package mips_pkg:
  - wb/m/exe widths and bit-index constants (WB_REG_WRITE=1, WB_MEM_TO_REG=0, M_BRANCH=2, M_MEM_READ=1, M_MEM_WRITE=0, EXE_REG_DST=3, EXE_ALU_OP_HI=2, EXE_ALU_OP_LO=1, EXE_ALU_SRC=0).
  - alu_op encodings.
  - Opcode constants: R=0, LW=35, SW=43, BEQ=4.
- One natural sub-module: load_use_detect, purely combinational, producing load_use from ex_valid, ex_m[1], ex_rt, id_valid, id_rs, id_rt and id_m[1].

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> all outputs 0. Release with an R-type in ID (wb=2, m=0, exe=12) -> next cycle ex_valid=1, ex_wb=2, ex_exe=12.
- Load-use: lw with ex_rt=8, then ID add with id_rs=8 -> stall=1 for exactly 1 cycle, bubble in EX (ex_valid=0, controls 0). Next cycle the add enters EX and stall_cycles=1.
- No false hazard:
  - lw with ex_rt=0 and id_rs=0 -> stall=0.
  - lw with ex_rt=9, then ID lw with id_rt=9 and id_rs=3 -> stall=0.
  - sw with id_rt=9 after lw with ex_rt=9 -> stall=1.
- Flush priority: load_use condition plus flush=1 in the same cycle -> stall=0, bubble in EX, stall_cycles unchanged.
- Saturation: force 70000 hazard cycles with CNT_W=16 -> stall_cycles=65535 and holds.
- Throughput: 10 independent R-type/beq instructions with id_valid=1 -> each appears in EX one cycle later, unchanged, and stall never asserts.
